// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter: grants whole CYC-framed bus cycles and routes ACK to the owner only.
// Define ZAP_WB_ARB_RR_EN for round-robin contention; default build uses fixed priority (master 0).
module zap_wb_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  // Master 0 (data side)
  input  logic        i_wb_cyc0,
  input  logic        i_wb_stb0,
  input  logic        i_wb_wen0,
  input  logic [3:0]  i_wb_sel0,
  input  logic [31:0] i_wb_adr0,
  input  logic [31:0] i_wb_dat0,
  input  logic [2:0]  i_wb_cti0,
  output logic        o_wb_ack0,
  // Master 1 (instruction side)
  input  logic        i_wb_cyc1,
  input  logic        i_wb_stb1,
  input  logic        i_wb_wen1,
  input  logic [3:0]  i_wb_sel1,
  input  logic [31:0] i_wb_adr1,
  input  logic [31:0] i_wb_dat1,
  input  logic [2:0]  i_wb_cti1,
  output logic        o_wb_ack1,
  // External bus
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat,
  output logic [1:0]  o_grant
);

  localparam logic [2:0] CtiClassic = 3'b000;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  state_e contend_st;

  // Read data is fanned out to both masters outside this block.
  logic [31:0] unused_dat;
  assign unused_dat = i_wb_dat;

`ifdef ZAP_WB_ARB_RR_EN
  assign contend_st = last_q ? StOwn0 : StOwn1;
`else
  assign contend_st = StOwn0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (i_wb_cyc0 && i_wb_cyc1) begin
          state_d = contend_st;
        end else if (i_wb_cyc0) begin
          state_d = StOwn0;
        end else if (i_wb_cyc1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        // Ownership only moves once the owner has closed its cycle.
        if (!i_wb_cyc0) begin
          last_d  = 1'b0;
          state_d = i_wb_cyc1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (!i_wb_cyc1) begin
          last_d  = 1'b1;
          state_d = i_wb_cyc0 ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Outputs depend on registered state plus the owner's inputs; i_wb_ack only feeds the acks.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_wen  = 1'b0;
    o_wb_sel  = 4'h0;
    o_wb_adr  = 32'h0;
    o_wb_dat  = 32'h0;
    o_wb_cti  = CtiClassic;
    o_wb_ack0 = 1'b0;
    o_wb_ack1 = 1'b0;
    o_grant   = 2'b00;
    unique case (state_q)
      StOwn0: begin
        o_wb_cyc  = i_wb_cyc0;
        o_wb_stb  = i_wb_stb0;
        o_wb_wen  = i_wb_wen0;
        o_wb_sel  = i_wb_sel0;
        o_wb_adr  = i_wb_adr0;
        o_wb_dat  = i_wb_dat0;
        o_wb_cti  = i_wb_cti0;
        o_wb_ack0 = i_wb_ack;
        o_grant   = 2'b01;
      end
      StOwn1: begin
        o_wb_cyc  = i_wb_cyc1;
        o_wb_stb  = i_wb_stb1;
        o_wb_wen  = i_wb_wen1;
        o_wb_sel  = i_wb_sel1;
        o_wb_adr  = i_wb_adr1;
        o_wb_dat  = i_wb_dat1;
        o_wb_cti  = i_wb_cti1;
        o_wb_ack1 = i_wb_ack;
        o_grant   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Directed self-checking bench for zap_wb_arbiter; expectations follow the build's contention policy.
module tb_zap_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        cyc0, stb0, wen0, cyc1, stb1, wen1;
  logic [3:0]  sel0, sel1;
  logic [31:0] adr0, dat0, adr1, dat1;
  logic [2:0]  cti0, cti1;
  logic        ack0, ack1;
  logic        o_cyc, o_stb, o_wen;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat;
  logic [2:0]  o_cti;
  logic        ack_in;
  logic [31:0] dat_in;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] BurstStb = 7'b1010101;

  zap_wb_arbiter dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wb_cyc0 (cyc0),
    .i_wb_stb0 (stb0),
    .i_wb_wen0 (wen0),
    .i_wb_sel0 (sel0),
    .i_wb_adr0 (adr0),
    .i_wb_dat0 (dat0),
    .i_wb_cti0 (cti0),
    .o_wb_ack0 (ack0),
    .i_wb_cyc1 (cyc1),
    .i_wb_stb1 (stb1),
    .i_wb_wen1 (wen1),
    .i_wb_sel1 (sel1),
    .i_wb_adr1 (adr1),
    .i_wb_dat1 (dat1),
    .i_wb_cti1 (cti1),
    .o_wb_ack1 (ack1),
    .o_wb_cyc  (o_cyc),
    .o_wb_stb  (o_stb),
    .o_wb_wen  (o_wen),
    .o_wb_sel  (o_sel),
    .o_wb_adr  (o_adr),
    .o_wb_dat  (o_dat),
    .o_wb_cti  (o_cti),
    .i_wb_ack  (ack_in),
    .i_wb_dat  (dat_in),
    .o_grant   (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    cyc0 = 0; stb0 = 0; wen0 = 0; sel0 = 4'h0; adr0 = 32'h0; dat0 = 32'h0; cti0 = 3'b000;
    cyc1 = 0; stb1 = 0; wen1 = 0; sel1 = 4'h0; adr1 = 32'h0; dat1 = 32'h0; cti1 = 3'b000;
    ack_in = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_masters();
    dat_in = 32'h5555_AAAA;
    #1;
    n_checks++;
    if (grant !== 2'b00 || o_cyc !== 1'b0 || o_stb !== 1'b0 || o_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got grant=%b cyc=%b stb=%b wen=%b want 00 0 0 0",
               grant, o_cyc, o_stb, o_wen);
    end
    n_checks++;
    if (o_sel !== 4'h0 || o_adr !== 32'h0 || o_dat !== 32'h0 || o_cti !== 3'b000 ||
        ack0 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got sel=%h adr=%h dat=%h cti=%b ack0=%b ack1=%b want all 0",
               o_sel, o_adr, o_dat, o_cti, ack0, ack1);
    end
    tick();
    tick();
    rst = 1'b0;
    // Master 0 write; then async reset while it owns the bus and ack is high.
    cyc0 = 1; stb0 = 1; wen0 = 1; sel0 = 4'h3; adr0 = 32'hA000_0004; dat0 = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (grant !== 2'b00 || o_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_cycle: got grant=%b cyc=%b want 00 0", grant, o_cyc);
    end
    tick();
    #1;
    n_checks++;
    if (grant !== 2'b01 || o_cyc !== 1'b1 || o_wen !== 1'b1 || o_sel !== 4'h3 ||
        o_adr !== 32'hA000_0004 || o_dat !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL own0_copy: got grant=%b cyc=%b wen=%b sel=%h adr=%h dat=%h want 01 1 1 3 a0000004 deadbeef",
               grant, o_cyc, o_wen, o_sel, o_adr, o_dat);
    end
    ack_in = 1;
    #1;
    n_checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL own0_ack: got ack0=%b ack1=%b want 1 0", ack0, ack1);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_cyc !== 1'b0 || grant !== 2'b00 || ack0 !== 1'b0 || ack1 !== 1'b0 || o_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got cyc=%b grant=%b ack0=%b ack1=%b adr=%h want 0 00 0 0 0",
               o_cyc, grant, ack0, ack1, o_adr);
    end
    clear_masters();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_m1();
    int acks1;
    int acks0;
    acks1 = 0;
    acks0 = 0;
    cyc1 = 1; stb1 = 1; wen1 = 0; sel1 = 4'hF; adr1 = 32'h0000_1000; cti1 = 3'b000;
    #1;
    n_checks++;
    if (o_cyc !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL m1_cycle_n: got cyc=%b grant=%b want 0 00", o_cyc, grant);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      ack_in = (i == 3);
      #1;
      n_checks++;
      if (o_adr !== 32'h0000_1000 || grant !== 2'b10 || o_sel !== 4'hF || o_stb !== 1'b1) begin
        n_fail++;
        $display("FAIL m1_bus_beat%0d: got adr=%h grant=%b sel=%h stb=%b want 00001000 10 f 1",
                 i, o_adr, grant, o_sel, o_stb);
      end
      if (ack1 === 1'b1) acks1++;
      if (ack0 !== 1'b0) acks0++;
    end
    tick();
    clear_masters();
    #1;
    if (ack1 === 1'b1) acks1++;
    if (ack0 !== 1'b0) acks0++;
    n_checks++;
    if (acks1 != 1 || acks0 != 0) begin
      n_fail++;
      $display("FAIL m1_ack_count: got ack1 pulses=%0d ack0 pulses=%0d want 1 0", acks1, acks0);
    end
    tick();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL m1_release: got grant=%b want 00", grant);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    cyc0 = 1; stb0 = 1; adr0 = 32'h0000_0A00;
    cyc1 = 1; stb1 = 1; adr1 = 32'h0000_0B00;
    tick();
    n_checks++;
    if (grant !== 2'b01 || o_adr !== 32'h0000_0A00) begin
      n_fail++;
      $display("FAIL simul_first: got grant=%b adr=%h want 01 00000a00", grant, o_adr);
    end
    cyc0 = 0; stb0 = 0;
    tick();
    n_checks++;
    if (grant !== 2'b10 || o_adr !== 32'h0000_0B00 || o_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_handover: got grant=%b adr=%h cyc=%b want 10 00000b00 1",
               grant, o_adr, o_cyc);
    end
    clear_masters();
    tick();
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] exp_cti;
    pulse_reset();
    cyc0 = 1; adr0 = 32'h0000_2000;
    cyc1 = 1; stb1 = 1; adr1 = 32'h0000_3000;
    tick();
    for (int i = 0; i < 7; i++) begin
      exp_cti = (i == 6) ? 3'b111 : 3'b010;
      stb0   = BurstStb[i];
      cti0   = exp_cti;
      ack_in = BurstStb[i];
      #1;
      n_checks++;
      if (grant !== 2'b01 || o_cti !== exp_cti || o_stb !== BurstStb[i] ||
          ack0 !== BurstStb[i] || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_step%0d: got grant=%b cti=%b stb=%b ack0=%b ack1=%b want 01 %b %b %b 0",
                 i, grant, o_cti, o_stb, ack0, ack1, exp_cti, BurstStb[i], BurstStb[i]);
      end
      tick();
    end
    cyc0 = 0; stb0 = 0; cti0 = 3'b000; ack_in = 0;
    #1;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_release_cycle: got grant=%b want 01", grant);
    end
    tick();
    n_checks++;
    if (grant !== 2'b10 || o_adr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL burst_handover: got grant=%b adr=%h want 10 00003000", grant, o_adr);
    end
    clear_masters();
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
`ifdef ZAP_WB_ARB_RR_EN
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b01;
`endif
      cyc0 = 1; stb0 = 1; cyc1 = 1; stb1 = 1;
      tick();
      ack_in = 1;
      #1;
      n_checks++;
      if (grant !== exp_grant || {ack1, ack0} !== exp_grant) begin
        n_fail++;
        $display("FAIL contend_txn%0d: got grant=%b acks=%b want %b %b",
                 k, grant, {ack1, ack0}, exp_grant, exp_grant);
      end
      tick();
      clear_masters();
      tick();
    end
  endtask

  task automatic test_stray_ack();
    clear_masters();
    tick();
    ack_in = 1;
    #1;
    n_checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || o_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: got ack0=%b ack1=%b cyc=%b want 0 0 0", ack0, ack1, o_cyc);
    end
    tick();
    ack_in = 0;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_ack_state: got grant=%b want 00", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_simultaneous();
    test_burst();
    test_contention();
    test_stray_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
